read_analyse_data: RTL and testbench

READ_ANALYSE_DATA -- requirements
Module: read_analyse_data

---
 rtl/read_analyse_data.sv | 158 +++++++++++++++
 tb/tb_read_analyse_data.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/read_analyse_data.sv
// Current-modulation downlink receiver: slices ADC samples against a baseline, hunts for a
// 23-bit frame, samples bits mid-period and publishes the payload byte when the frame validates.
module read_analyse_data #(
    parameter int          BIT_PERIOD = 200000,
    parameter logic [11:0] THRESH     = 12'd64
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        swiptAlive,
    // "program" and "type" are SystemVerilog keywords, hence prog / frame_type
    input  logic [1:0]  prog,
    input  logic        readDataIn,
    input  logic [11:0] ADC,
    input  logic [11:0] meanCurrent,
    input  logic [1:0]  mode,
    input  logic [1:0]  frame_type,
    output logic        din,
    output logic        dataInReady,
    output logic [7:0]  dataIn,
    output logic [7:0]  sumChecker,
    output logic        checkSumBit,
    output logic [1:0]  state_dbg
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] HUNT   = 2'd1;
    localparam logic [1:0] SAMPLE = 2'd2;
    localparam logic [1:0] CHECK  = 2'd3;

    localparam int          TW        = $clog2(BIT_PERIOD);
    localparam logic [TW-1:0] HALF_LOAD = TW'(BIT_PERIOD / 2 - 1);
    localparam logic [TW-1:0] FULL_LOAD = TW'(BIT_PERIOD - 1);
    localparam logic [5:0]  PREAMBLE  = 6'b101010;
    localparam logic [3:0]  TRAILER   = 4'b0101;

    logic [1:0]    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [4:0]    bit_idx_q, bit_idx_d;
    logic [22:0]   shift_q, shift_d;
    logic          din_q, din_d;
    logic          ready_q, ready_d;
    logic [7:0]    data_q, data_d;
    logic [7:0]    sum_q, sum_d;
    logic          chk_q, chk_d;

    logic          en;
    logic [2:0]    pre_sel;
    logic          pre_bit;
    logic          frame_ok;
    logic [7:0]    rx_data;
    logic [7:0]    rx_pop;

    assign en = swiptAlive & (prog == 2'b11) & readDataIn;

    // Frame layout in the shift register, MSB first as received
    assign rx_data  = shift_q[12:5];
    assign frame_ok = (shift_q[22:17] == PREAMBLE) && (shift_q[16:15] == mode) &&
                      (shift_q[14:13] == frame_type) && (shift_q[3:0] == TRAILER);

    always_comb begin
        rx_pop = 8'd0;
        for (int i = 0; i < 8; i++) begin
            rx_pop = rx_pop + {7'd0, rx_data[i]};
        end
    end

    always_comb begin
        pre_sel = 3'd5 - bit_idx_q[2:0];
        pre_bit = (bit_idx_q < 5'd6) ? PREAMBLE[pre_sel] : 1'b0;
    end

    always_comb begin
        // 13-bit compare so meanCurrent + THRESH never wraps
        din_d     = ({1'b0, ADC} > ({1'b0, meanCurrent} + {1'b0, THRESH}));
        state_d   = state_q;
        timer_d   = timer_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        ready_d   = 1'b0;
        data_d    = data_q;
        sum_d     = sum_q;
        chk_d     = chk_q;

        if (!en) begin
            state_d   = IDLE;
            timer_d   = '0;
            bit_idx_d = '0;
            shift_d   = '0;
        end else begin
            case (state_q)
                IDLE: state_d = HUNT;
                HUNT: begin
                    if (din_q) begin
                        timer_d   = HALF_LOAD;
                        bit_idx_d = '0;
                        state_d   = SAMPLE;
                    end
                end
                SAMPLE: begin
                    if (timer_q == '0) begin
                        shift_d   = {shift_q[21:0], din_q};
                        timer_d   = FULL_LOAD;
                        bit_idx_d = bit_idx_q + 5'd1;
                        if ((bit_idx_q < 5'd6) && (din_q != pre_bit)) begin
                            state_d = HUNT;
                        end else if (bit_idx_q == 5'd22) begin
                            state_d = CHECK;
                        end
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end
                CHECK: begin
                    if (frame_ok) begin
                        data_d  = rx_data;
                        sum_d   = rx_pop;
                        chk_d   = (shift_q[4] == ^rx_data);
                        ready_d = 1'b1;
                    end
                    state_d = HUNT;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            din_q     <= 1'b0;
            ready_q   <= 1'b0;
            data_q    <= 8'h00;
            sum_q     <= 8'h00;
            chk_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            din_q     <= din_d;
            ready_q   <= ready_d;
            data_q    <= data_d;
            sum_q     <= sum_d;
            chk_q     <= chk_d;
        end
    end

    assign din         = din_q;
    assign dataInReady = ready_q;
    assign dataIn      = data_q;
    assign sumChecker  = sum_q;
    assign checkSumBit = chk_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_read_analyse_data.sv
// Directed bench for read_analyse_data: a frame table plus hand-written sequences for
// slicer boundaries, re-hunting, enable drop, program gating and mid-frame reset.
module tb_read_analyse_data;

    localparam int BP = 16;

    logic        clk = 1'b0;
    logic        nrst;
    logic        swiptAlive;
    logic [1:0]  prog;
    logic        readDataIn;
    logic [11:0] ADC;
    logic [11:0] meanCurrent;
    logic [1:0]  mode;
    logic [1:0]  frame_type;
    logic        din;
    logic        dataInReady;
    logic [7:0]  dataIn;
    logic [7:0]  sumChecker;
    logic        checkSumBit;
    logic [1:0]  state_dbg;

    read_analyse_data #(.BIT_PERIOD(BP), .THRESH(12'd64)) dut (
        .clk(clk), .nrst(nrst), .swiptAlive(swiptAlive), .prog(prog),
        .readDataIn(readDataIn), .ADC(ADC), .meanCurrent(meanCurrent),
        .mode(mode), .frame_type(frame_type), .din(din), .dataInReady(dataInReady),
        .dataIn(dataIn), .sumChecker(sumChecker), .checkSumBit(checkSumBit),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] f_mode;
        logic [1:0] f_type;
        logic [7:0] f_data;
        logic       f_par;
        logic [3:0] f_tr;
        int         exp_pulses;
        logic [7:0] exp_data;
        logic [7:0] exp_sum;
        logic       exp_chk;
    } vec_t;

    vec_t vecs[8];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   pulse_cnt = 0;
    logic prev_ready = 1'b0;

    // Pulse monitor: counts dataInReady pulses and flags back-to-back highs
    always @(negedge clk) begin
        if (dataInReady === 1'b1) begin
            pulse_cnt++;
            n_tests++;
            if (prev_ready === 1'b1) begin
                n_fail++;
                $display("FAIL ready_twice: dataInReady high on consecutive cycles, required single pulse");
            end
        end
        prev_ready = dataInReady;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic logic [22:0] mk(input logic [1:0] m, input logic [1:0] t,
                                       input logic [7:0] d, input logic p, input logic [3:0] tr);
        return {6'b101010, m, t, d, p, tr};
    endfunction

    task automatic send_bit(input logic b);
        ADC = b ? 12'd1200 : 12'd900;
        repeat (BP) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [22:0] bits, input int n);
        for (int i = 0; i < n; i++) send_bit(bits[22-i]);
    endtask

    task automatic send_frame(input logic [22:0] bits);
        send_bits(bits, 23);
        repeat (3) send_bit(1'b0);
    endtask

    initial begin
        int cnt0;
        logic [11:0] adc_vals[4];

        vecs[0] = '{2'b01, 2'b10, 8'hA5, 1'b0, 4'h5, 1, 8'hA5, 8'd4, 1'b1};
        vecs[1] = '{2'b01, 2'b10, 8'hA5, 1'b1, 4'h5, 1, 8'hA5, 8'd4, 1'b0};
        vecs[2] = '{2'b11, 2'b10, 8'h3C, 1'b0, 4'h5, 0, 8'hA5, 8'd4, 1'b0};
        vecs[3] = '{2'b01, 2'b10, 8'h3C, 1'b0, 4'h7, 0, 8'hA5, 8'd4, 1'b0};
        vecs[4] = '{2'b01, 2'b10, 8'h01, 1'b1, 4'h5, 1, 8'h01, 8'd1, 1'b1};
        vecs[5] = '{2'b01, 2'b10, 8'hFF, 1'b1, 4'h5, 1, 8'hFF, 8'd8, 1'b0};
        vecs[6] = '{2'b01, 2'b01, 8'h00, 1'b0, 4'h5, 0, 8'hFF, 8'd8, 1'b0};
        vecs[7] = '{2'b01, 2'b10, 8'h00, 1'b0, 4'h5, 1, 8'h00, 8'd0, 1'b1};

        // Clock/reset
        nrst = 1'b0; swiptAlive = 1'b1; prog = 2'b11; readDataIn = 1'b0;
        ADC = 12'd900; meanCurrent = 12'd1000; mode = 2'b01; frame_type = 2'b10;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_din", {31'd0, din}, 32'd0);
        check("rst_ready", {31'd0, dataInReady}, 32'd0);
        check("rst_dataIn", {24'd0, dataIn}, 32'h00);
        check("rst_sum", {24'd0, sumChecker}, 32'd0);
        check("rst_chk", {31'd0, checkSumBit}, 32'd0);
        check("rst_state", {30'd0, state_dbg}, 32'd0);
        nrst = 1'b1;

        // Slicer boundaries, receive window closed
        @(negedge clk); ADC = 12'd1064;
        @(negedge clk); @(negedge clk);
        check("slice_1064", {31'd0, din}, 32'd0);
        ADC = 12'd1065;
        #1 check("slice_latency", {31'd0, din}, 32'd0);
        @(negedge clk);
        check("slice_1065", {31'd0, din}, 32'd1);
        meanCurrent = 12'd4095;
        adc_vals[0] = 12'd4095; adc_vals[1] = 12'd0; adc_vals[2] = 12'd2000;
        adc_vals[3] = 12'($urandom_range(0, 4095));
        for (int i = 0; i < 4; i++) begin
            ADC = adc_vals[i];
            @(negedge clk);
            check($sformatf("slice_mean4095_%0d", i), {31'd0, din}, 32'd0);
        end
        meanCurrent = 12'd1000; ADC = 12'd900;
        @(negedge clk);
        check("idle_when_closed", {30'd0, state_dbg}, 32'd0);
        readDataIn = 1'b1;
        repeat (3) @(negedge clk);
        check("hunt_when_open", {30'd0, state_dbg}, 32'd1);
        @(posedge clk); #1;

        // Frame table
        for (int i = 0; i < 8; i++) begin
            cnt0 = pulse_cnt;
            send_frame(mk(vecs[i].f_mode, vecs[i].f_type, vecs[i].f_data, vecs[i].f_par, vecs[i].f_tr));
            check($sformatf("v%0d_pulses", i), pulse_cnt - cnt0, vecs[i].exp_pulses);
            check($sformatf("v%0d_dataIn", i), {24'd0, dataIn}, {24'd0, vecs[i].exp_data});
            check($sformatf("v%0d_sum", i), {24'd0, sumChecker}, {24'd0, vecs[i].exp_sum});
            check($sformatf("v%0d_chk", i), {31'd0, checkSumBit}, {31'd0, vecs[i].exp_chk});
        end

        // readDataIn dropped after 10 bits, then a fresh frame
        cnt0 = pulse_cnt;
        send_bits(mk(2'b01, 2'b10, 8'h3C, 1'b0, 4'h5), 10);
        readDataIn = 1'b0; ADC = 12'd900;
        repeat (20) @(posedge clk); #1;
        check("drop_idle", {30'd0, state_dbg}, 32'd0);
        check("drop_no_pulse", pulse_cnt - cnt0, 32'd0);
        readDataIn = 1'b1;
        repeat (2) send_bit(1'b0);
        send_frame(mk(2'b01, 2'b10, 8'h3C, 1'b0, 4'h5));
        check("drop_pulses", pulse_cnt - cnt0, 32'd1);
        check("drop_dataIn", {24'd0, dataIn}, 32'h3C);
        check("drop_sum", {24'd0, sumChecker}, 32'd4);
        check("drop_chk", {31'd0, checkSumBit}, 32'd1);

        // Corrupted preamble followed by a valid frame
        cnt0 = pulse_cnt;
        send_bits({6'b101110, 17'd0}, 6);
        repeat (3) send_bit(1'b0);
        send_frame(mk(2'b01, 2'b10, 8'h5A, 1'b0, 4'h5));
        check("rehunt_pulses", pulse_cnt - cnt0, 32'd1);
        check("rehunt_dataIn", {24'd0, dataIn}, 32'h5A);
        check("rehunt_sum", {24'd0, sumChecker}, 32'd4);
        check("rehunt_chk", {31'd0, checkSumBit}, 32'd1);

        // Wrong program during a valid frame: outputs held
        cnt0 = pulse_cnt;
        prog = 2'b10;
        send_frame(mk(2'b01, 2'b10, 8'hFF, 1'b0, 4'h5));
        check("prog_state", {30'd0, state_dbg}, 32'd0);
        check("prog_pulses", pulse_cnt - cnt0, 32'd0);
        check("prog_dataIn", {24'd0, dataIn}, 32'h5A);
        check("prog_sum", {24'd0, sumChecker}, 32'd4);
        check("prog_chk", {31'd0, checkSumBit}, 32'd1);
        prog = 2'b11;
        repeat (2) send_bit(1'b0);

        // Reset mid-frame
        cnt0 = pulse_cnt;
        send_bits(mk(2'b01, 2'b10, 8'hA5, 1'b0, 4'h5), 12);
        nrst = 1'b0;
        #2;
        check("arst_state", {30'd0, state_dbg}, 32'd0);
        check("arst_dataIn", {24'd0, dataIn}, 32'h00);
        check("arst_sum", {24'd0, sumChecker}, 32'd0);
        check("arst_chk", {31'd0, checkSumBit}, 32'd0);
        ADC = 12'd900;
        repeat (2) @(posedge clk); #1;
        nrst = 1'b1;
        repeat (26 * BP) @(posedge clk); #1;
        check("arst_no_pulse", pulse_cnt - cnt0, 32'd0);
        check("arst_din", {31'd0, din}, 32'd0);
        check("arst_dataIn_after", {24'd0, dataIn}, 32'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
